// File: rtl/dmem_arbiter.sv
// Two-port arbiter (core LSU / host loader) for the single data-memory port, IDLE->ACCESS->RESP.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed core priority with a host starvation guard.
module dmem_arbiter #(
  parameter int DEPTH    = 256,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        host_err,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, next;
  logic        owner;   // 0 = core, 1 = host
  logic        l_we;
  logic [31:0] l_addr, l_wdata;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        host_win, legal;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;         // preferred port when both request
  assign host_win = host_req && (!core_req || rr_ptr);
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  assign host_win = host_req && (!core_req || (wait_cnt == CW'(MAX_WAIT)));
`endif

  assign legal = (l_addr[1:0] == 2'b00) && (l_addr <= 32'(DEPTH - 4));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      l_we     <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr   <= 1'b0;
`else
      wait_cnt <= '0;
`endif
    end else begin
      state <= next;
      if (state == IDLE) begin
        if (core_req || host_req) begin
          owner   <= host_win;
          l_we    <= host_win ? host_we    : core_we;
          l_addr  <= host_win ? host_addr  : core_addr;
          l_wdata <= host_win ? host_wdata : core_wdata;
`ifdef DMEM_ARB_RR_EN
          rr_ptr  <= ~host_win;
`endif
        end
`ifndef DMEM_ARB_RR_EN
        // counts lost contested cycles; the host can only lose when the core also requests
        if (!host_req || host_win) wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 1'b1;
`endif
      end
      if (state == ACCESS) begin
        rsp_data <= (legal && !l_we) ? mem_rdata : 32'h0;
        rsp_err  <= !legal;
      end
    end
  end

  always_comb begin
    next        = state;
    core_gnt    = 1'b0;
    host_gnt    = 1'b0;
    core_rvalid = 1'b0;
    host_rvalid = 1'b0;
    core_rdata  = '0;
    host_rdata  = '0;
    core_err    = 1'b0;
    host_err    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: if (core_req || host_req) begin
        // gated by rst so the grant is silent while reset is held
        core_gnt = rst && !host_win;
        host_gnt = rst && host_win;
        next     = ACCESS;
      end
      ACCESS: begin
        if (legal) begin
          mem_addr  = l_addr;
          mem_wr_en = l_we;
          mem_rd_en = !l_we;
          mem_wdata = l_we ? l_wdata : 32'h0;
        end
        next = RESP;
      end
      RESP: begin
        if (owner) begin
          host_rvalid = 1'b1;
          host_rdata  = rsp_data;
          host_err    = rsp_err;
        end else begin
          core_rvalid = 1'b1;
          core_rdata  = rsp_data;
          core_err    = rsp_err;
        end
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-byte memory behind the mem_* port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, host_req, host_we;
  logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
  logic        core_gnt, core_rvalid, core_err, host_gnt, host_rvalid, host_err;
  logic [31:0] core_rdata, host_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(256), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // OR of every output; zero means the block is fully quiet
  function automatic logic [31:0] all_out();
    return {31'h0, core_gnt | core_rvalid | core_err | host_gnt | host_rvalid | host_err |
            mem_wr_en | mem_rd_en} | core_rdata | host_rdata | mem_addr | mem_wdata;
  endfunction

  // Single uncontested transaction, checking every phase. Starts just after a rising edge.
  task automatic txn(input bit host, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input bit ok, input logic [31:0] exp_rd, input string tag);
    if (host) begin host_req = 1; host_we = we; host_addr = addr; host_wdata = wd; end
    else      begin core_req = 1; core_we = we; core_addr = addr; core_wdata = wd; end
    @(negedge clk);
    chk({tag, " gnt"}, {30'h0, core_gnt, host_gnt}, host ? 32'd1 : 32'd2);
    chk({tag, " idle mem"}, {30'h0, mem_wr_en, mem_rd_en}, 32'd0);
    @(posedge clk); #1;
    core_req = 0; host_req = 0;
    @(negedge clk);
    chk({tag, " wr_en"}, {31'h0, mem_wr_en}, {31'h0, we & ok});
    chk({tag, " rd_en"}, {31'h0, mem_rd_en}, {31'h0, ~we & ok});
    chk({tag, " addr"}, mem_addr, ok ? addr : 32'h0);
    if (we && ok) chk({tag, " wdata"}, mem_wdata, wd);
    chk({tag, " acc gnt"}, {30'h0, core_gnt, host_gnt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " rvalid"}, {30'h0, core_rvalid, host_rvalid}, host ? 32'd1 : 32'd2);
    chk({tag, " err"}, {31'h0, host ? host_err : core_err}, {31'h0, ~ok});
    chk({tag, " rdata"}, host ? host_rdata : core_rdata, exp_rd);
    chk({tag, " resp mem"}, {30'h0, mem_wr_en, mem_rd_en}, 32'd0);
    @(posedge clk); #1;
  endtask

  string seq;
  int    ngrant;

  initial begin
    rst = 0; core_req = 1; host_req = 1; core_we = 0; host_we = 0;
    core_addr = 0; core_wdata = 0; host_addr = 0; host_wdata = 0;
    #2;
    chk("reset outputs", all_out(), 32'h0);
    @(negedge clk);
    chk("reset outputs held", all_out(), 32'h0);
    core_req = 0; host_req = 0;
    rst = 1;
    @(posedge clk); #1;
    chk("idle no req", all_out(), 32'h0);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 1, 32'h0, "core st 0x10");
    txn(0, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, "core ld 0x10");
    txn(1, 1, 32'h0, 32'h5, 1, 32'h0, "host st 0x0");
    txn(1, 1, 32'h4, 32'h7, 1, 32'h0, "host st 0x4");
    txn(0, 0, 32'h4, 32'h0, 1, 32'h7, "core ld 0x4");
    txn(1, 0, 32'h0, 32'h0, 1, 32'h5, "host ld 0x0");
    txn(1, 0, 32'h3, 32'h0, 0, 32'h0, "host ld 0x3");
    txn(0, 1, 32'hFD, 32'hCAFEF00D, 0, 32'h0, "core st 0xFD");
    txn(0, 1, 32'hFC, 32'hA5A5A5A5, 1, 32'h0, "core st 0xFC");
    txn(1, 0, 32'hFC, 32'h0, 1, 32'hA5A5A5A5, "host ld 0xFC");
    txn(1, 0, 32'h100, 32'h0, 0, 32'h0, "host ld 0x100");

    // contention: both requests held, record grant order
    core_req = 1; core_we = 0; core_addr = 32'h0;
    host_req = 1; host_we = 0; host_addr = 32'h4;
    seq = ""; ngrant = 0;
    for (int c = 0; c < 60 && ngrant < 10; c++) begin
      @(negedge clk);
      if (core_gnt && host_gnt) chk("double gnt", 32'd1, 32'd0);
      if (core_rvalid && host_rvalid) chk("double rvalid", 32'd1, 32'd0);
      if (core_gnt) begin seq = {seq, "C"}; ngrant++; end
      if (host_gnt) begin seq = {seq, "H"}; ngrant++; end
    end
    @(posedge clk); #1;
    core_req = 0; host_req = 0;
    tests++;
`ifdef DMEM_ARB_RR_EN
    assert (seq == "CHCHCHCHCH") else begin
      fails++; $error("FAIL grant order: observed %s expected CHCHCHCHCH", seq);
    end
`else
    assert (seq == "CCCCHCCCCH") else begin
      fails++; $error("FAIL grant order: observed %s expected CCCCHCCCCH", seq);
    end
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post contention idle", all_out(), 32'h0);

    // reset in the ACCESS cycle of a core store
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'h12345678;
    @(negedge clk);
    chk("rst-case gnt", {31'h0, core_gnt}, 32'd1);
    @(posedge clk); #1;
    core_req = 0; host_req = 1; host_addr = 32'h8;
    chk("rst-case wr_en pre", {31'h0, mem_wr_en}, 32'd1);
    #1 rst = 0;
    #1;
    chk("rst-case wr_en drop", {31'h0, mem_wr_en}, 32'd0);
    chk("rst-case all out", all_out(), 32'h0);
    @(posedge clk); #1;
    chk("rst-case held", all_out(), 32'h0);
    host_req = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    txn(0, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, "post-rst ld 0x10");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
